// File: rtl/sbmips_cu.sv
`default_nettype none
// ============================================================================
// sbmips_cu : Moore control unit for the stack-based multicycle MIPS datapath
// Revision  : 1.0
// ============================================================================
module sbmips_cu #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      Inst,
  output logic            PCsrc,
  output logic            PCwrite,
  output logic            PCwriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Ild,
  output logic            Ssrc,
  output logic            Push,
  output logic            Pop,
  output logic            Tos,
  output logic            Bld,
  output logic            ALUsrc1,
  output logic [1:0]      ALUsrc2,
  output logic [1:0]      ALUop,
  output logic [CNTW-1:0] icount
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_ALB = 4'd2,
    S_ALX = 4'd3,
    S_NOT = 4'd4,
    S_PSH = 4'd5,
    S_POP = 4'd6,
    S_JMP = 4'd7,
    S_JZ  = 4'd8
  } state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [CNTW-1:0] icount_q;

  // Only the opcode drives control; the address field goes straight to the datapath.
  logic unused_addr;
  assign unused_addr = ^Inst[4:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IF;
      op_q     <= 2'b00;
      icount_q <= '0;
    end else begin
      case (state_q)
        S_IF: begin
          state_q  <= S_ID;
          icount_q <= icount_q + CNT_ONE;
        end
        S_ID: begin
          // The ALU function is latched here so ALX stays a pure function of state.
          op_q <= Inst[6:5];
          case (Inst[7:5])
            3'b000, 3'b001, 3'b010: state_q <= S_ALB;
            3'b011:                 state_q <= S_NOT;
            3'b100:                 state_q <= S_PSH;
            3'b101:                 state_q <= S_POP;
            3'b110:                 state_q <= S_JMP;
            default:                state_q <= S_JZ;
          endcase
        end
        S_ALB:   state_q <= S_ALX;
        default: state_q <= S_IF;
      endcase
    end
  end

  // Outputs are gated by rst so they drop the moment reset is asserted.
  always_comb begin
    PCsrc       = 1'b0;
    PCwrite     = 1'b0;
    PCwriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Ild         = 1'b0;
    Ssrc        = 1'b0;
    Push        = 1'b0;
    Pop         = 1'b0;
    Tos         = 1'b0;
    Bld         = 1'b0;
    ALUsrc1     = 1'b0;
    ALUsrc2     = 2'b00;
    ALUop       = 2'b00;
    if (rst) begin
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          Ild     = 1'b1;
          PCwrite = 1'b1;
          ALUsrc2 = 2'b10;
        end
        S_ID: Tos = 1'b1;
        S_ALB: begin
          Tos = 1'b1;
          Pop = 1'b1;
          Bld = 1'b1;
        end
        S_ALX: begin
          Tos     = 1'b1;
          ALUsrc1 = 1'b1;
          ALUop   = op_q;
          Pop     = 1'b1;
          Push    = 1'b1;
        end
        S_NOT: begin
          Tos     = 1'b1;
          ALUsrc1 = 1'b1;
          ALUop   = 2'b11;
          Pop     = 1'b1;
          Push    = 1'b1;
        end
        S_PSH: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          Ssrc    = 1'b1;
          Push    = 1'b1;
        end
        S_POP: begin
          Tos      = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
          Pop      = 1'b1;
        end
        S_JMP: begin
          PCsrc   = 1'b1;
          PCwrite = 1'b1;
        end
        S_JZ: begin
          Tos         = 1'b1;
          Pop         = 1'b1;
          ALUsrc1     = 1'b1;
          ALUsrc2     = 2'b01;
          PCsrc       = 1'b1;
          PCwriteCond = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign icount = icount_q;

endmodule
`default_nettype wire

// File: tb/tb_sbmips_cu.sv
`default_nettype none
// Scoreboard bench for sbmips_cu: stimulus queues expected per-cycle controls,
// a negedge monitor pops and compares them.
module tb_sbmips_cu;

  localparam int CNTW = 4;

  localparam int S_IF  = 0;
  localparam int S_ID  = 1;
  localparam int S_ALB = 2;
  localparam int S_ALX = 3;
  localparam int S_NOT = 4;
  localparam int S_PSH = 5;
  localparam int S_POP = 6;
  localparam int S_JMP = 7;
  localparam int S_JZ  = 8;
  localparam int S_RST = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      Inst;
  logic            PCsrc, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, Ild;
  logic            Ssrc, Push, Pop, Tos, Bld, ALUsrc1;
  logic [1:0]      ALUsrc2, ALUop;
  logic [CNTW-1:0] icount;

  sbmips_cu #(.CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .Inst(Inst),
    .PCsrc(PCsrc), .PCwrite(PCwrite), .PCwriteCond(PCwriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .Ild(Ild), .Ssrc(Ssrc),
    .Push(Push), .Pop(Pop), .Tos(Tos), .Bld(Bld), .ALUsrc1(ALUsrc1),
    .ALUsrc2(ALUsrc2), .ALUop(ALUop), .icount(icount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              stage;
    logic [16:0]     ctrl;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   icnt       = 0;

  function automatic string sname(int s);
    case (s)
      S_IF:    return "IF";
      S_ID:    return "ID";
      S_ALB:   return "ALB";
      S_ALX:   return "ALX";
      S_NOT:   return "NOT";
      S_PSH:   return "PSH";
      S_POP:   return "POP";
      S_JMP:   return "JMP";
      S_JZ:    return "JZ";
      default: return "RESET";
    endcase
  endfunction

  function automatic logic [16:0] dut_ctrl();
    return {PCsrc, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, Ild, Ssrc,
            Push, Pop, Tos, Bld, ALUsrc1, ALUsrc2, ALUop};
  endfunction

  // Reference: the control word each phase of an instruction must present.
  function automatic logic [16:0] exp_ctrl(int s, logic [2:0] op);
    logic pcsrc, pcw, pcwc, iord, mrd, mwr, ild, ssrc, push, pop, tos, bld, a1;
    logic [1:0] a2, aop;
    {pcsrc, pcw, pcwc, iord, mrd, mwr, ild, ssrc, push, pop, tos, bld, a1} = '0;
    a2 = 2'b00;
    aop = 2'b00;
    case (s)
      S_IF:  begin mrd = 1; ild = 1; pcw = 1; a2 = 2'b10; end
      S_ID:  tos = 1;
      S_ALB: begin tos = 1; pop = 1; bld = 1; end
      S_ALX: begin tos = 1; a1 = 1; aop = op[1:0]; pop = 1; push = 1; end
      S_NOT: begin tos = 1; a1 = 1; aop = 2'b11; pop = 1; push = 1; end
      S_PSH: begin iord = 1; mrd = 1; ssrc = 1; push = 1; end
      S_POP: begin tos = 1; iord = 1; mwr = 1; pop = 1; end
      S_JMP: begin pcsrc = 1; pcw = 1; end
      S_JZ:  begin tos = 1; pop = 1; a1 = 1; a2 = 2'b01; pcsrc = 1; pcwc = 1; end
      default: ;
    endcase
    return {pcsrc, pcw, pcwc, iord, mrd, mwr, ild, ssrc, push, pop, tos, bld, a1, a2, aop};
  endfunction

  task automatic expect_stage(int s, logic [2:0] op);
    exp_t e;
    e.stage = s;
    e.ctrl  = exp_ctrl(s, op);
    e.cnt   = CNTW'(icnt);
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 of an IF cycle; returns at posedge+1 of the next IF.
  task automatic run_instr(logic [2:0] op, logic [4:0] addr, bit abort);
    int stages[$];
    Inst = 8'($urandom);
    expect_stage(S_IF, op);
    step();
    icnt = (icnt + 1) % (1 << CNTW);
    Inst = {op, addr};
    expect_stage(S_ID, op);
    step();
    case (op)
      3'd0, 3'd1, 3'd2: stages = '{S_ALB, S_ALX};
      3'd3:             stages = '{S_NOT};
      3'd4:             stages = '{S_PSH};
      3'd5:             stages = '{S_POP};
      3'd6:             stages = '{S_JMP};
      default:          stages = '{S_JZ};
    endcase
    foreach (stages[i]) begin
      if (abort && stages[i] == S_ALB) begin
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (dut_ctrl() !== 17'h0 || icount !== '0) begin
          miscompares++;
          $display("FAIL async_reset_in_ALB: ctrl=%h icount=%0d, expected ctrl=0 icount=0",
                   dut_ctrl(), icount);
        end
        icnt = 0;
        expect_stage(S_RST, op);
        step();
        expect_stage(S_RST, op);
        step();
        rst = 1'b1;
        return;
      end
      expect_stage(stages[i], op);
      step();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (dut_ctrl() !== e.ctrl || icount !== e.cnt) begin
          miscompares++;
          $display("FAIL %s: ctrl=%h icount=%0d, expected ctrl=%h icount=%0d",
                   sname(e.stage), dut_ctrl(), icount, e.ctrl, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [2:0] op;
    bit         ab;
    rst  = 1'b0;
    Inst = 8'h00;
    repeat (3) begin
      step();
      expect_stage(S_RST, 3'd0);
    end
    step();
    rst = 1'b1;

    run_instr(3'b000, 5'd0,  1'b0);   // ADD
    run_instr(3'b100, 5'd5,  1'b0);   // PUSH
    run_instr(3'b101, 5'd5,  1'b0);   // POP
    run_instr(3'b111, 5'd10, 1'b0);   // JZ, zero flag clear in datapath
    run_instr(3'b111, 5'd10, 1'b0);   // JZ, zero flag set in datapath
    run_instr(3'b001, 5'd3,  1'b0);   // SUB
    run_instr(3'b010, 5'd3,  1'b0);   // AND
    run_instr(3'b110, 5'd7,  1'b0);   // JMP
    run_instr(3'b000, 5'd1,  1'b1);   // ADD aborted in ALB
    repeat (16) run_instr(3'b011, 5'd0, 1'b0);
    repeat (40) begin
      op = 3'($urandom_range(0, 7));
      ab = (op < 3) && ($urandom_range(0, 5) == 0);
      run_instr(op, 5'($urandom), ab);
    end

    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sbmips_cu.md
SBMIPS_CU -- requirements
Module: sbmips_cu

Interface
REQ-001 The block SHALL have one parameter: CNTW, default 16, width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Inst, input, 8 bits: the instruction register contents from the datapath, with opcode in Inst[7:5] and address in Inst[4:0].
REQ-005 The block SHALL have the following 1-bit outputs to the datapath: PCsrc, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, Ild, Ssrc, Push, Pop, Tos, Bld and ALUsrc1.
REQ-006 The block SHALL have ALUsrc2 and ALUop as 2-bit outputs to the datapath.
REQ-007 The block SHALL have port icount, output, CNTW bits: the count of fetched instructions.

Function
REQ-008 The block SHALL be a Moore FSM, with every control output decoded from the state only.
REQ-009 Any control output not listed as asserted for a state SHALL be 0 in that state.
REQ-010 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
REQ-011 ALUop encoding SHALL be: 00 add, 01 sub, 10 and, 11 not.
REQ-012 ALUsrc2 encoding SHALL be: 00 B, 01 zero, 10 one, 11 stack top.
REQ-013 PCsrc SHALL select 0 = ALU result and 1 = Inst[4:0]; IorD SHALL select 0 = PC and 1 = Inst[4:0].
REQ-014 Ssrc SHALL select 0 = ALU result and 1 = memory data; ALUsrc1 SHALL select 0 = PC and 1 = stack top.
REQ-015 The datapath stack treats Pop and Push asserted in the same cycle as replace-top; the block SHALL rely on this for ALU results.
REQ-016 States SHALL be IF, ID, ALB, ALX, NOT, PSH, POP, JMP and JZ.
REQ-017 IF SHALL assert MemRead, Ild, PCwrite, ALUsrc2=10 and ALUop=00 (IorD=0, ALUsrc1=0, PCsrc=0), and SHALL transition to ID.
REQ-018 ID SHALL assert Tos.
REQ-019 ID SHALL transition on Inst[7:5]: 000/001/010 go to ALB, 011 to NOT, 100 to PSH, 101 to POP, 110 to JMP, 111 to JZ.
REQ-020 ALB SHALL assert Tos, Pop and Bld (B takes the top, and the top is removed), then transition to ALX.
REQ-021 ALX SHALL assert Tos, ALUsrc1=1, ALUsrc2=00, ALUop=Inst[6:5], Ssrc=0, Pop and Push, then transition to IF.
REQ-022 The ALX result SHALL be second-from-top OP former-top.
REQ-023 NOT SHALL assert Tos, ALUsrc1=1, ALUop=11, Ssrc=0, Pop and Push, then transition to IF.
REQ-024 PSH SHALL assert IorD, MemRead, Ssrc=1 and Push, then transition to IF.
REQ-025 POP SHALL assert Tos, IorD, MemWrite and Pop, then transition to IF.
REQ-026 JMP SHALL assert PCsrc=1 and PCwrite, then transition to IF.
REQ-027 JZ SHALL assert Tos, Pop, ALUsrc1=1, ALUsrc2=01, ALUop=00, PCsrc=1 and PCwriteCond, then transition to IF.
REQ-028 In JZ, the branch SHALL be taken only when the datapath zero flag is 1, and the top SHALL be popped whether or not the branch is taken.
REQ-029 Instruction latency SHALL be: ALU binary ops 4 cycles; NOT, PUSH, POP, JMP and JZ 3 cycles each.
REQ-030 Inst SHALL be sampled for decode only in ID and in execute states; Inst changes in IF SHALL NOT affect the current transition.
REQ-031 icount SHALL increment by 1 on each clock edge leaving IF.
REQ-032 icount SHALL wrap from all-ones to 0 silently.
REQ-033 Unreachable state encodings SHALL transition to IF with all outputs 0.

Reset
REQ-034 While rst=0, the state SHALL be IF, icount SHALL be 0, and all control outputs SHALL be forced to 0, regardless of clk.
REQ-035 Reset asserted in any state, including mid-instruction, SHALL abort the instruction immediately.
REQ-036 After rst rises, the first rising clk edge SHALL complete an IF cycle, so PC+1 and the instruction are loaded at that edge.

Verification
REQ-037 The bench SHALL cover reset: rst=0 for 3 cycles -> all outputs 0 and icount=0; rst=1 -> IF outputs (MemRead=1, Ild=1, PCwrite=1, ALUsrc2=10) in the first cycle.
REQ-038 The bench SHALL cover ADD: Inst=8'b000_00000 -> state sequence IF, ID, ALB, ALX, IF; ALX shows Pop=1, Push=1, ALUop=00, ALUsrc2=00; icount +1.
REQ-039 The bench SHALL cover PUSH and POP: Inst=8'b100_00101 -> PSH with IorD=1, MemRead=1, Ssrc=1, Push=1; then Inst=8'b101_00101 -> POP with MemWrite=1, Pop=1.
REQ-040 The bench SHALL cover JZ: Inst=8'b111_01010 in the JZ state -> PCwriteCond=1, PCsrc=1, PCwrite=0, Pop=1; the next state is IF for both zero=0 and zero=1.
REQ-041 The bench SHALL cover asynchronous reset mid-instruction: drop rst while in ALB, between clock edges -> outputs 0 before the next edge; after release, the sequence resumes at IF.
REQ-042 The bench SHALL cover counter wrap: with CNTW=4, 16 NOT instructions -> icount returns to 0 with no other effect.
